// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
package keypad_pkg;

  // Scanner control states.
  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } kp_state_e;

  // Map a raw 4x4 key index (row*4 + column) to the printed digit.
  // The raw index is taken zero-extended to 8 bits so out-of-range codes
  // can be recognised and flagged as 16.
  function automatic logic [4:0] keymap4x4(input logic [7:0] raw);
    logic [4:0] d;
    case (raw)
      8'd0:    d = 5'd1;
      8'd1:    d = 5'd2;
      8'd2:    d = 5'd3;
      8'd3:    d = 5'd10;
      8'd4:    d = 5'd4;
      8'd5:    d = 5'd5;
      8'd6:    d = 5'd6;
      8'd7:    d = 5'd11;
      8'd8:    d = 5'd7;
      8'd9:    d = 5'd8;
      8'd10:   d = 5'd9;
      8'd11:   d = 5'd12;
      8'd12:   d = 5'd15;
      8'd13:   d = 5'd0;
      8'd14:   d = 5'd14;
      8'd15:   d = 5'd13;
      default: d = 5'd16;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/keypad_scanner_tick_gen.sv
// Scan-rate divider: one single-cycle tick every SCAN_DIV clocks.
module keypad_tick_gen #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count wraps to zero on the tick cycle.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  // Divider counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: walking column drive, synchronised rows,
// press/release debounce and a single-entry valid/ready event register.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLS           = 4,
  parameter int unsigned SCAN_DIV       = 4,
  parameter int unsigned DEBOUNCE_SCANS = 3,
  localparam int unsigned KEY_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ROWS-1:0]  fila,
  output logic [COLS-1:0]  col,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             key_held,
  output logic             key_overrun
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS);

  logic              tick;
  logic [ROWS-1:0]   sync1_q;
  logic [ROWS-1:0]   rows_s_q;

  kp_state_e         state_q, state_d;
  logic [COLS-1:0]   col_q, col_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  rel_q, rel_d;
  logic [ROWS-1:0]   cap_rows_q, cap_rows_d;
  logic [KEY_W-1:0]  cap_code_q, cap_code_d;
  logic [KEY_W-1:0]  code_q, code_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;

  logic              emit;
  logic [KEY_W-1:0]  emit_code;
  logic [KEY_W-1:0]  code_now;
  logic              rows_single;
  logic [COLS-1:0]  col_rot;

  keypad_tick_gen #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick (
    .clk_i (clk),
    .rst_i (rst),
    .tick_o(tick)
  );

  // Two-flop synchroniser for the asynchronous row inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      rows_s_q <= '0;
    end else begin
      sync1_q  <= fila;
      rows_s_q <= sync1_q;
    end
  end

  // Decode the sampled row and driven column into a raw key index.
  always_comb begin
    int unsigned ridx;
    int unsigned cidx;
    ridx = 0;
    cidx = 0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (rows_s_q[r]) ridx = r;
    end
    for (int unsigned c = 0; c < COLS; c++) begin
      if (col_q[c]) cidx = c;
    end
    code_now    = KEY_W'(ridx * COLS + cidx);
    rows_single = (rows_s_q != '0) && ((rows_s_q & (rows_s_q - ROWS'(1))) == '0);
  end

  assign col_rot = {col_q[COLS-2:0], col_q[COLS-1]};

  // Scan/debounce/held next-state logic; everything advances only on tick.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    cnt_d      = cnt_q;
    rel_d      = rel_q;
    cap_rows_d = cap_rows_q;
    cap_code_d = cap_code_q;
    emit       = 1'b0;
    emit_code  = cap_code_q;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (rows_single) begin
            cap_rows_d = rows_s_q;
            cap_code_d = code_now;
            cnt_d      = CNT_W'(1);
            if (DEBOUNCE_SCANS == 1) begin
              emit      = 1'b1;
              emit_code = code_now;
              rel_d     = '0;
              state_d   = HELD;
            end else begin
              state_d = DEBOUNCE;
            end
          end else begin
            col_d = col_rot;
          end
        end
        DEBOUNCE: begin
          if (rows_s_q == cap_rows_q) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q + CNT_W'(1) == CNT_LAST) begin
              emit    = 1'b1;
              rel_d   = '0;
              state_d = HELD;
            end
          end else begin
            cnt_d   = '0;
            col_d   = col_rot;
            state_d = SCAN;
          end
        end
        HELD: begin
          if (rows_s_q == '0) begin
            if (rel_q + CNT_W'(1) == CNT_LAST) begin
              rel_d   = '0;
              state_d = SCAN;
            end else begin
              rel_d = rel_q + CNT_W'(1);
            end
          end else begin
            rel_d = '0;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // Event register: load when free or being consumed, otherwise flag overrun.
  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (emit) begin
      if (!valid_q || key_ready) begin
        code_d  = emit_code;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && key_ready) begin
      valid_d = 1'b0;
    end
  end

  // Control and output state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SCAN;
      col_q      <= COLS'(1);
      cnt_q      <= '0;
      rel_q      <= '0;
      cap_rows_q <= '0;
      cap_code_q <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      cnt_q      <= cnt_d;
      rel_q      <= rel_d;
      cap_rows_q <= cap_rows_d;
      cap_code_q <= cap_code_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

  assign col         = col_q;
  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_held    = (state_q == HELD);
  assign key_overrun = ovr_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (4x4, SCAN_DIV=4, DEBOUNCE_SCANS=3).
module tb_keypad_scanner;

  localparam int NR = 4;
  localparam int NC = 4;
  localparam int DIV = 4;
  localparam int DEB = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] fila = '0;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic       key_held;
  logic       key_overrun;

  int checks = 0;
  int failures = 0;

  keypad_scanner #(
    .ROWS(NR),
    .COLS(NC),
    .SCAN_DIV(DIV),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fila(fila),
    .col(col),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_held(key_held),
    .key_overrun(key_overrun)
  );

  always #5 clk = ~clk;

  // Physical keypad: one pressed key, optionally shorted to the next row.
  bit kp_down = 0;
  bit kp_ghost = 0;
  bit noise_en = 0;
  int kp_r = 0;
  int kp_c = 0;

  // Reference model state (spec-level quantities).
  localparam int PH_SCAN = 0;
  localparam int PH_DEB  = 1;
  localparam int PH_HELD = 2;
  int         m_div = 0;        // clocks since last tick
  int         m_cidx = 0;       // driven column index
  int         m_phase = PH_SCAN;
  int         m_match = 0;      // matching ticks while debouncing
  int         m_zero = 0;       // consecutive zero-row ticks while held
  logic [3:0] m_cap = '0;
  int         m_cap_code = 0;
  int         m_code = 0;
  bit         m_valid = 0;
  bit         m_ovr = 0;
  logic [3:0] m_pipe[$];        // fila samples still inside the synchroniser

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] kp_fila(input int cidx);
    logic [3:0] f;
    f = '0;
    if (kp_down && cidx == kp_c) begin
      f[kp_r] = 1'b1;
      if (kp_ghost) f[(kp_r + 1) % NR] = 1'b1;
    end
    return f;
  endfunction

  task automatic model_step(input bit r, input logic [3:0] f, input bit rdy);
    logic [3:0] rs;
    bit tick, emit;
    if (r) begin
      m_div = 0; m_cidx = 0; m_phase = PH_SCAN; m_match = 0; m_zero = 0;
      m_cap = '0; m_cap_code = 0; m_code = 0; m_valid = 0; m_ovr = 0;
      m_pipe = '{4'd0, 4'd0};
      return;
    end
    rs = m_pipe.pop_front();
    m_pipe.push_back(f);
    m_div++;
    tick = (m_div == DIV);
    if (tick) m_div = 0;
    emit = 0;
    if (tick) begin
      if (m_phase == PH_SCAN) begin
        if ($countones(rs) == 1) begin
          for (int i = 0; i < NR; i++) if (rs[i]) m_cap_code = i * NC + m_cidx;
          m_cap = rs;
          m_match = 1;
          m_phase = PH_DEB;
        end else begin
          m_cidx = (m_cidx + 1) % NC;
        end
      end else if (m_phase == PH_DEB) begin
        if (rs == m_cap) begin
          m_match++;
          if (m_match == DEB) begin
            emit = 1; m_phase = PH_HELD; m_zero = 0;
          end
        end else begin
          m_phase = PH_SCAN;
          m_cidx = (m_cidx + 1) % NC;
        end
      end else begin
        if (rs == 0) m_zero++;
        else m_zero = 0;
        if (m_zero == DEB) begin
          m_phase = PH_SCAN; m_zero = 0;
        end
      end
    end
    m_ovr = 0;
    if (emit) begin
      if (!m_valid || rdy) begin
        m_code = m_cap_code; m_valid = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare after it.
  task automatic cycle(input bit r, input bit rdy);
    logic [3:0] f;
    f = kp_fila(m_cidx);
    if (noise_en && $urandom_range(0, 24) == 0) f = f ^ 4'($urandom_range(1, 15));
    rst = r;
    key_ready = rdy;
    fila = f;
    @(posedge clk);
    model_step(r, f, rdy);
    #1;
    chk("col", {28'd0, col}, 32'(1 << m_cidx));
    chk("key_valid", {31'd0, key_valid}, 32'(m_valid));
    chk("key_code", {28'd0, key_code}, 32'(m_code));
    chk("key_held", {31'd0, key_held}, 32'(m_phase == PH_HELD));
    chk("key_overrun", {31'd0, key_overrun}, 32'(m_ovr));
  endtask

  task automatic press(input int r, input int c);
    kp_r = r; kp_c = c; kp_down = 1;
  endtask

  task automatic wait_valid(input bit rdy, input string nm);
    int n = 0;
    while (!key_valid && n < 300) begin cycle(0, rdy); n++; end
    chk(nm, {31'd0, key_valid}, 32'd1);
  endtask

  task automatic wait_held(input bit val, input bit rdy, input string nm);
    int n = 0;
    while (key_held != val && n < 300) begin cycle(0, rdy); n++; end
    chk(nm, {31'd0, key_held}, 32'(val));
  endtask

  typedef struct {
    logic [7:0] raw;
    logic [4:0] digit;
  } km_vec_t;

  km_vec_t    km_tab[18];
  logic [3:0] rot_tab[5];

  initial begin
    bit saw_valid, saw_held, saw_ovr;
    int n;

    km_tab = '{'{8'd0, 5'd1}, '{8'd1, 5'd2}, '{8'd2, 5'd3}, '{8'd3, 5'd10},
               '{8'd4, 5'd4}, '{8'd5, 5'd5}, '{8'd6, 5'd6}, '{8'd7, 5'd11},
               '{8'd8, 5'd7}, '{8'd9, 5'd8}, '{8'd10, 5'd9}, '{8'd11, 5'd12},
               '{8'd12, 5'd15}, '{8'd13, 5'd0}, '{8'd14, 5'd14}, '{8'd15, 5'd13},
               '{8'd16, 5'd16}, '{8'd255, 5'd16}};
    rot_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    foreach (km_tab[i])
      chk($sformatf("keymap_%0d", km_tab[i].raw),
          {27'd0, keypad_pkg::keymap4x4(km_tab[i].raw)}, {27'd0, km_tab[i].digit});

    // Reset and rotation.
    cycle(1, 0);
    cycle(1, 0);
    chk("rst_col", {28'd0, col}, {28'd0, rot_tab[0]});
    chk("rst_valid", {31'd0, key_valid}, 32'd0);
    for (int t = 1; t < 5; t++) begin
      for (int k = 0; k < DIV; k++) cycle(0, 0);
      chk($sformatf("rot_%0d", t), {28'd0, col}, {28'd0, rot_tab[t]});
    end

    // Single press of raw 6 (row 1, column 2).
    press(1, 2);
    wait_valid(1, "press6_valid");
    chk("press6_code", {28'd0, key_code}, 32'd6);
    chk("press6_col", {28'd0, col}, 32'b0100);
    chk("press6_held", {31'd0, key_held}, 32'd1);
    cycle(0, 1);
    chk("press6_pulse", {31'd0, key_valid}, 32'd0);
    kp_down = 0;
    wait_held(0, 1, "press6_release");

    // Bounce: two matching ticks, then the key drops.
    press(0, 1);
    n = 0;
    while (!(m_phase == PH_DEB && m_match == 2) && n < 300) begin cycle(0, 1); n++; end
    chk("bounce_reach", 32'(m_match), 32'd2);
    kp_down = 0;
    saw_valid = 0; saw_held = 0;
    for (int k = 0; k < 40; k++) begin
      cycle(0, 1);
      saw_valid |= key_valid;
      saw_held |= key_held;
    end
    chk("bounce_no_event", {31'd0, saw_valid}, 32'd0);
    chk("bounce_no_held", {31'd0, saw_held}, 32'd0);

    // Ghost: rows 0 and 1 together on column 0.
    press(0, 0);
    kp_ghost = 1;
    saw_valid = 0; saw_held = 0;
    for (int k = 0; k < 48; k++) begin
      cycle(0, 1);
      saw_valid |= key_valid;
      saw_held |= key_held;
    end
    chk("ghost_no_event", {31'd0, saw_valid}, 32'd0);
    chk("ghost_no_held", {31'd0, saw_held}, 32'd0);
    kp_ghost = 0;
    kp_down = 0;
    for (int k = 0; k < 8; k++) cycle(0, 1);

    // Overrun: raw 13 left unconsumed, then raw 0 pressed.
    press(3, 1);
    wait_valid(0, "ovr_first_valid");
    chk("ovr_first_code", {28'd0, key_code}, 32'd13);
    kp_down = 0;
    wait_held(0, 0, "ovr_first_release");
    press(0, 0);
    n = 0;
    saw_ovr = 0;
    while (!saw_ovr && n < 300) begin cycle(0, 0); saw_ovr = key_overrun; n++; end
    chk("ovr_pulse", {31'd0, saw_ovr}, 32'd1);
    chk("ovr_code_kept", {28'd0, key_code}, 32'd13);
    chk("ovr_valid_kept", {31'd0, key_valid}, 32'd1);
    cycle(0, 0);
    chk("ovr_one_clk", {31'd0, key_overrun}, 32'd0);
    kp_down = 0;
    wait_held(0, 0, "ovr_second_release");
    chk("ovr_pre_xfer_code", {28'd0, key_code}, 32'd13);
    cycle(0, 1);
    chk("ovr_xfer_clear", {31'd0, key_valid}, 32'd0);
    for (int k = 0; k < 6; k++) cycle(0, 1);
    chk("ovr_single_xfer", {31'd0, key_valid}, 32'd0);

    // Reset while held; the same key is reported again afterwards.
    press(2, 1);
    wait_valid(1, "rsth_valid");
    chk("rsth_code", {28'd0, key_code}, 32'd9);
    for (int k = 0; k < 6; k++) cycle(0, 1);
    chk("rsth_held", {31'd0, key_held}, 32'd1);
    cycle(1, 1);
    cycle(1, 1);
    chk("rsth_col", {28'd0, col}, 32'd1);
    chk("rsth_valid", {31'd0, key_valid}, 32'd0);
    chk("rsth_held_clr", {31'd0, key_held}, 32'd0);
    wait_valid(1, "rsth_fresh_valid");
    chk("rsth_fresh_code", {28'd0, key_code}, 32'd9);
    kp_down = 0;
    wait_held(0, 1, "rsth_release");

    // Randomised presses, bounce, ghosts, backpressure and occasional reset.
    noise_en = 1;
    for (int it = 0; it < 50; it++) begin
      int plen, rlen, rbias;
      if ($urandom_range(0, 9) == 0) begin cycle(1, 0); cycle(1, 0); end
      kp_r = $urandom_range(0, NR - 1);
      kp_c = $urandom_range(0, NC - 1);
      kp_ghost = ($urandom_range(0, 7) == 0);
      rbias = $urandom_range(0, 3);
      plen = $urandom_range(8, 120);
      rlen = $urandom_range(8, 80);
      for (int k = 0; k < plen; k++) begin
        kp_down = ($urandom_range(0, 11) != 0);
        cycle(0, $urandom_range(0, 3) < rbias);
      end
      kp_down = 0;
      for (int k = 0; k < rlen; k++) cycle(0, $urandom_range(0, 3) < rbias);
    end
    noise_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
